// File: rtl/sa_flow_cell_pkg.sv
// params: shared systolic-array compute type, cell FSM states and limits
package params;
    typedef struct packed {
        logic [3:0] op;
        logic [3:0] fmt;
    } full_type_t;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} sa_state_e;
    localparam int SA_MAX_DELAY = 4;
endpackage

// File: rtl/sa_flow_cell_delay_line.sv
// sa_delay_line: stall-aware shift line whose data is forced to zero whenever valid is low
module sa_delay_line #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [WIDTH-1:0] in,
    input  logic             valid_in,
    output logic [WIDTH-1:0] out,
    output logic             valid_out
);
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] v;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < DEPTH; i++) d[i] <= '0;
        end else if (!hold) begin
            v[0] <= valid_in;
            d[0] <= valid_in ? in : '0;
            for (int i = 1; i < DEPTH; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end
    assign out       = d[DEPTH-1];
    assign valid_out = v[DEPTH-1];
endmodule

// File: rtl/sa_flow_cell.sv
// sa_flow_cell: systolic edge cell forwarding operands/enables, latching tile type and flagging tile completion
// Optional SA_MISMATCH_CHK_EN: sticky left/above enable mismatch flag plus assertion.
import params::*;
module sa_flow_cell #(
    parameter int DATA_W  = 32,
    parameter int H_LANES = 1,
    parameter int V_LANES = 1,
    parameter int DELAY   = 1,
    parameter int CNT_W   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       stall,
    input  logic                       en_left,
    input  logic [H_LANES*DATA_W-1:0]  data_left,
    input  logic                       en_above,
    input  logic [V_LANES*DATA_W-1:0]  data_above,
    output logic                       en_right,
    output logic [H_LANES*DATA_W-1:0]  data_right,
    output logic                       en_below,
    output logic [V_LANES*DATA_W-1:0]  data_below,
    output logic                       en,
    input  logic                       type_load,
    input  full_type_t                 type_in,
    output logic                       type_load_out,
    output full_type_t                 type_out,
    input  logic [CNT_W-1:0]           tile_len,
    output logic                       tile_done,
    output logic                       busy,
    output logic                       err_mismatch,
    input  logic                       err_clr
);
    localparam int DCW = $clog2(SA_MAX_DELAY);
    sa_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [DCW-1:0]   dcnt;
    assign en   = en_left && en_above && !stall;
    assign busy = state != IDLE;
    sa_delay_line #(.WIDTH(H_LANES*DATA_W), .DEPTH(DELAY)) u_h (
        .clk(clk), .rst_n(rst_n), .hold(stall),
        .in(data_left), .valid_in(en_left), .out(data_right), .valid_out(en_right)
    );
    sa_delay_line #(.WIDTH(V_LANES*DATA_W), .DEPTH(DELAY)) u_v (
        .clk(clk), .rst_n(rst_n), .hold(stall),
        .in(data_above), .valid_in(en_above), .out(data_below), .valid_out(en_below)
    );
    // The drain counter lets the last beat reach the far end of the line before tile_done fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            dcnt          <= '0;
            tile_done     <= 1'b0;
            type_load_out <= 1'b0;
            type_out      <= '0;
        end else if (!stall) begin
            tile_done     <= 1'b0;
            type_load_out <= type_load && state == IDLE;
            if (type_load && state == IDLE) type_out <= type_in;
            case (state)
                IDLE: if (en) begin
                    cnt   <= CNT_W'(1);
                    state <= tile_len == '0 ? DRAIN : RUN;
                    dcnt  <= DCW'(DELAY - 1);
                end
                RUN: if (en) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == tile_len) begin
                        state <= DRAIN;
                        dcnt  <= DCW'(DELAY - 1);
                    end
                end
                DRAIN: if (dcnt == '0) begin
                    tile_done <= 1'b1;
                    state     <= IDLE;
                    cnt       <= '0;
                end else begin
                    dcnt <= dcnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SA_MISMATCH_CHK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) err_mismatch <= 1'b0;
        else if (!stall && en_left != en_above) err_mismatch <= 1'b1;
        else if (err_clr) err_mismatch <= 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst_n && !stall) assert (en_left == en_above) else $error("sa_flow_cell: enable mismatch");
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_mismatch   = 1'b0;
`endif
endmodule

// File: tb/tb_sa_flow_cell.sv
// tb_sa_flow_cell: scoreboard bench for sa_flow_cell with directed vectors
module tb_sa_flow_cell;
    import params::*;
    localparam int DW = 32, HL = 2, VL = 1, DL = 2, CW = 8;
`ifdef SA_MISMATCH_CHK_EN
    localparam logic MCHK = 1'b1;
`else
    localparam logic MCHK = 1'b0;
`endif
    localparam logic [63:0] IDL = 64'hFFFF_0000_1234_5678;
    localparam logic [31:0] IDA = 32'hCAFE_F00D;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, stall, en_left, en_above, en_right, en_below, en;
    logic [HL*DW-1:0] data_left, data_right;
    logic [VL*DW-1:0] data_above, data_below;
    logic type_load, type_load_out, tile_done, busy, err_mismatch, err_clr;
    full_type_t type_in, type_out;
    logic [CW-1:0] tile_len;

    sa_flow_cell #(.DATA_W(DW), .H_LANES(HL), .V_LANES(VL), .DELAY(DL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .en_left(en_left), .data_left(data_left), .en_above(en_above), .data_above(data_above),
        .en_right(en_right), .data_right(data_right), .en_below(en_below), .data_below(data_below),
        .en(en), .type_load(type_load), .type_in(type_in), .type_load_out(type_load_out),
        .type_out(type_out), .tile_len(tile_len), .tile_done(tile_done), .busy(busy),
        .err_mismatch(err_mismatch), .err_clr(err_clr)
    );

    typedef struct { logic [63:0] d; int due; } fwd_t;
    typedef struct { int cyc; int sel; logic [63:0] exp; string nm; } chk_t;
    fwd_t hq[$], vq[$];
    chk_t cq[$];
    int tq[$];
    int nchk = 0, nerr = 0, cyc = 0, uc = 0;
    logic adv = 1'b0;

    // cyc counts every edge; uc counts edges on which the forwarding lines shift
    always @(posedge clk) begin
        cyc++;
        adv = rst_n && !stall;
        if (adv) uc++;
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    task automatic fail(input string nm);
        nchk++;
        nerr++;
        $display("FAIL %s: got an output with no expectation pending (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [63:0] sig(input int s);
        case (s)
            0: return 64'(busy);
            1: return 64'(type_out);
            2: return 64'(type_load_out);
            3: return 64'(err_mismatch);
            4: return 64'(en);
            5: return 64'(en_right);
            6: return 64'(en_below);
            default: return 64'(tile_done);
        endcase
    endfunction

    always @(negedge clk) begin : mon
        fwd_t f;
        chk_t c;
        if (adv && en_right) begin
            if (hq.size() == 0) fail("right_unexpected");
            else begin
                f = hq.pop_front();
                chk("right_data", data_right, f.d);
                chk("right_latency", 64'(uc), 64'(f.due));
            end
        end
        if (adv && en_below) begin
            if (vq.size() == 0) fail("below_unexpected");
            else begin
                f = vq.pop_front();
                chk("below_data", 64'(data_below), f.d);
                chk("below_latency", 64'(uc), 64'(f.due));
            end
        end
        if (!en_right) chk("right_zero_gated", data_right, 64'd0);
        if (!en_below) chk("below_zero_gated", 64'(data_below), 64'd0);
        if (tile_done) begin
            if (tq.size() == 0) fail("tile_done_unexpected");
            else chk("tile_done_cycle", 64'(cyc), 64'(tq.pop_front()));
        end
        while (cq.size() != 0 && cq[0].cyc <= cyc) begin
            c = cq.pop_front();
            chk(c.nm, sig(c.sel), c.exp);
        end
    end

    task automatic at(input int sel, input string nm, input logic [63:0] e);
        cq.push_back('{cyc + 1, sel, e, nm});
    endtask

    task automatic drive(input logic el, input logic ea, input logic [63:0] dl, input logic [31:0] da,
                         input logic st = 1'b0, input logic tld = 1'b0, input logic [7:0] tin = 8'h00,
                         input logic clr = 1'b0);
        @(negedge clk);
        #1;
        en_left = el; en_above = ea; data_left = dl; data_above = da;
        stall = st; type_load = tld; type_in = full_type_t'(tin); err_clr = clr;
        if (rst_n && !st) begin
            if (el) hq.push_back('{dl, uc + DL});
            if (ea) vq.push_back('{64'(da), uc + DL});
        end
        at(4, "en", 64'(el && ea && !st));
    endtask

    task automatic idle_busy(input int b);
        for (int i = 1; i <= DL + 1; i++) begin
            drive(1'b0, 1'b0, IDL, IDA);
            at(0, "busy_drain", 64'(cyc + 1 - b < DL));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0; stall = 1'b0; en_left = 1'b0; en_above = 1'b0; data_left = '0; data_above = '0;
        type_load = 1'b0; type_in = '0; err_clr = 1'b0;
        hq.delete(); vq.delete(); cq.delete(); tq.delete();
        at(0, "rst_busy", 0); at(1, "rst_type_out", 0); at(2, "rst_type_load_out", 0);
        at(3, "rst_err", 0); at(5, "rst_en_right", 0); at(6, "rst_en_below", 0); at(7, "rst_tile_done", 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int b;
        rst_n = 1'b0; stall = 1'b0; en_left = 1'b0; en_above = 1'b0; data_left = '0; data_above = '0;
        type_load = 1'b0; type_in = '0; err_clr = 1'b0; tile_len = 8'd3;
        do_reset();
        // compute type latched only while idle
        drive(1'b0, 1'b0, IDL, IDA, 1'b0, 1'b1, 8'hA5);
        at(1, "type_load_idle", 64'hA5); at(2, "type_load_out_idle", 1);
        drive(1'b0, 1'b0, IDL, IDA);
        at(1, "type_hold", 64'hA5); at(2, "type_load_out_drop", 0);
        // four-beat tile, tile_len=3, with a refused type load during RUN
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b1, {32'(k) * 32'h0101_0101, 32'hDEAD_BEEF}, 32'hDEAD_BEEF,
                  1'b0, k == 3, 8'h5A);
            at(0, "busy_run", 1);
            if (k == 3) begin
                at(1, "type_run_ignored", 64'hA5);
                at(2, "type_load_out_run", 0);
            end
        end
        b = cyc + 1;
        tq.push_back(b + DL);
        idle_busy(b);
        // single-beat tile goes straight to drain
        tile_len = 8'd0;
        drive(1'b1, 1'b1, 64'h0000_0001_0000_0002, 32'h0000_0003);
        b = cyc + 1;
        tq.push_back(b + DL);
        at(0, "busy_len0", 1);
        idle_busy(b);
        // stream with a two-cycle stall in the middle of a long tile
        tile_len = 8'd200;
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 1'b1, {32'h5000_0000 + 32'(k), 32'hA000_0000 + 32'(k)}, 32'hB000_0000 + 32'(k),
                  k == 3 || k == 4);
            at(0, "busy_stream", 1);
        end
        drive(1'b0, 1'b0, IDL, IDA);
        at(0, "busy_stream_hold", 1);
        // abort the tile mid-run; flushed beats must not emerge and no tile_done may fire
        do_reset();
        tile_len = 8'd1;
        drive(1'b1, 1'b1, 64'h1111_2222_3333_4444, 32'h5555_6666);
        at(0, "busy_fresh", 1);
        drive(1'b1, 1'b1, 64'h7777_8888_9999_AAAA, 32'hBBBB_CCCC);
        b = cyc + 1;
        tq.push_back(b + DL);
        idle_busy(b);
        // enable mismatch and clearing
        drive(1'b1, 1'b0, 64'h0000_0000_0000_0ABC, IDA);
        at(3, "err_set", 64'(MCHK));
        drive(1'b0, 1'b0, IDL, IDA);
        at(3, "err_sticky", 64'(MCHK));
        drive(1'b0, 1'b0, IDL, IDA, 1'b0, 1'b0, 8'h00, 1'b1);
        at(3, "err_clear", 0);
        drive(1'b0, 1'b1, IDL, 32'h0000_0DEF, 1'b0, 1'b0, 8'h00, 1'b1);
        at(3, "err_set_beats_clr", 64'(MCHK));
        drive(1'b0, 1'b0, IDL, IDA, 1'b0, 1'b0, 8'h00, 1'b1);
        at(3, "err_clear2", 0);
        at(0, "busy_after_mismatch", 0);
        repeat (DL + 2) drive(1'b0, 1'b0, IDL, IDA);
        @(negedge clk);
        #2;
        chk("right_drained", 64'(hq.size()), 0);
        chk("below_drained", 64'(vq.size()), 0);
        chk("tile_done_all_seen", 64'(tq.size()), 0);
        chk("timed_checks_done", 64'(cq.size()), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/sa_flow_cell.md
Name: sa_flow_cell

Overview:
- Parametrised systolic-array edge cell; one per PE; successor of the per-PE enable/data forwarding cell.
- Forwards multi-lane operand data and enables right and below through a configurable-depth register line, with global stall.
- Latches the compute type once per tile through a load-pulse chain and counts beats to flag tile completion.
- Flags left/above enable mismatch in hardware.

Parameters:
- DATA_W, 32, bits per lane
- H_LANES, 1, lanes forwarded left→right
- V_LANES, 1, lanes forwarded above→below
- DELAY, 1, forwarding register stages (legal 1..4)
- CNT_W, 8, beat counter width; tile length up to 2^CNT_W

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- stall  in  1  global hold; freezes all state
- en_left  in  1  valid from left neighbour
- data_left  in  H_LANES*DATA_W  operands from left
- en_above  in  1  valid from above neighbour
- data_above  in  V_LANES*DATA_W  operands from above
- en_right  out  1  delayed en_left
- data_right  out  H_LANES*DATA_W  delayed data_left
- en_below  out  1  delayed en_above
- data_below  out  V_LANES*DATA_W  delayed data_above
- en  out  1  PE compute enable (combinational)
- type_load  in  1  load pulse for compute type
- type_in  in  params::full_type_t  compute type
- type_load_out  out  1  type_load delayed 1 cycle, to neighbours
- type_out  out  params::full_type_t  held compute type, to PE and neighbours
- tile_len  in  CNT_W  beats per tile minus 1
- tile_done  out  1  one-cycle pulse after last beat drained
- busy  out  1  FSM not IDLE
- err_mismatch  out  1  sticky enable mismatch flag
- err_clr  in  1  clears err_mismatch

Behaviour:
- Reset (rst_n=0 at posedge): all outputs 0, type_out='0, FSM=IDLE, beat counter 0, all delay stages invalid and zero. Reset mid-tile aborts; no tile_done.
- Reset has priority over stall; stall has priority over everything else. While stall=1 all registers hold (err_clr still applies).
- en = en_left && en_above && !stall.
- Forwarding: DELAY-stage line per direction. Stage 0 captures (en_x, en_x ? data_x : 0); each stage shifts on !stall. Outputs are the last stage, so latency is DELAY cycles. Data is zero whenever en_x is 0.
- Type: in IDLE, type_load=1 (and !stall) loads type_out<=type_in. type_load outside IDLE is ignored. type_load_out<=type_load && state==IDLE.
- FSM:
  - IDLE → RUN on first en=1. Counter := 1, or tile_done path if tile_len==0.
  - RUN: each en=1 increments counter. On en=1 with counter==tile_len, go to DRAIN and load a drain counter with DELAY-1.
  - DRAIN: decrement each unstalled cycle. At 0, pulse tile_done and go to IDLE.
  - tile_len==0: first beat goes straight IDLE→DRAIN.
  - en=1 arriving in DRAIN is forwarded but not counted.
- busy = state != IDLE.
- Counter wraps modulo 2^CNT_W; tile_len sampled each compare.
- Mismatch: en_left != en_above with !stall sets err_mismatch next cycle. err_clr clears it; set wins over a simultaneous clear.

Optional Feature:
- SA_MISMATCH_CHK_EN defined: mismatch detection as above, plus an immediate assertion raising $error on mismatch.
- Undefined: err_mismatch tied 0, err_clr ignored, no assertion.

Decomposition:
- Package params (existing) holds full_type_t.
- Add to params: sa_state_e {IDLE, RUN, DRAIN}, and constant SA_MAX_DELAY=4.
- Sub-module sa_delay_line (WIDTH, DEPTH; ports: in, valid_in, hold, out, valid_out) holds the stall-aware, zero-gated shift register. Instantiated once per direction.

Test Plan:
- DELAY=1, en_left=en_above=1, data_left=0xDEADBEEF → data_right=0xDEADBEEF and en_right=1 one cycle later. Drop en → data_right=0 next cycle.
- DELAY=3, stall=1 for 2 cycles mid-stream → output sequence identical to unstalled run, shifted by 2 cycles; en=0 while stalled.
- tile_len=3, 4 enabled beats, DELAY=2 → busy rises after beat 1; tile_done pulses exactly 2 cycles after beat 4 (DRAIN entered on beat 4, DELAY-1 extra cycle); busy=0 same cycle.
- type_load with type_in=T1 in IDLE → type_out=T1 and type_load_out=1 next cycle. type_load with T2 during RUN → type_out stays T1, type_load_out=0.
- en_left=1, en_above=0 with SA_MISMATCH_CHK_EN → err_mismatch=1 next cycle; stays set until err_clr. Without the macro it stays 0.
- rst_n=0 during RUN at beat 2 → all outputs 0 next cycle, no tile_done; a fresh tile afterwards counts from 1.
